// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex driver for a NUM_DIGITS-digit common-anode seven-segment display.
// Latency: an/seg/dp/frame_done are registered, so they are one cycle behind the scan counters.
// Backpressure: none; load is always accepted and takes effect at the next frame boundary, or at once when it lands on the boundary.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   enable         1 = scanning; 0 = display dark, counters frozen
//   load           capture value/dp_in this cycle
//   value          hex nibbles, nibble i drives digit i (digit 0 least significant)
//   dp_in          per-digit decimal point request (1 = lit)
//   blank_lz       1 = suppress leading zeros (digit 0 is always shown)
//   seg            {A..G}, A = bit 6, active-low
//   dp             decimal point, active-low
//   an             anode select, active-low, one-hot-low or all high
//   frame_done     one-cycle pulse after the last digit's dwell ends
module seven_seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]        divCnt;
    logic [IDX_W-1:0]        digitIdx;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [NUM_DIGITS-1:0]   pendingDp;
    logic                    pendingValid;
    logic [4*NUM_DIGITS-1:0] active;
    logic [NUM_DIGITS-1:0]   activeDp;

    logic                    dwellEnd;
    logic                    frameBoundary;
    logic [3:0]              curNibble;
    logic                    curDp;
    logic                    upperZero;
    logic                    blankDigit;
    logic [NUM_DIGITS-1:0]   anSel;

    // Segment pattern ABCDEFG, 1 = lit; inverted at the output for the active-low pins.
    function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    assign dwellEnd      = (divCnt == DIV_LAST);
    // Only a live scan can reach a boundary; a frozen display never swaps data.
    assign frameBoundary = enable && dwellEnd && (digitIdx == IDX_LAST);

    // Scan counters: dwell counter inside a digit slot, digit index across slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt   <= '0;
            digitIdx <= '0;
        end else if (enable) begin
            if (dwellEnd) begin
                divCnt   <= '0;
                digitIdx <= (digitIdx == IDX_LAST) ? '0 : digitIdx + 1'b1;
            end else begin
                divCnt <= divCnt + 1'b1;
            end
        end
    end

    // Double buffer: writes park in pending and move to active only between frames,
    // so a frame is always drawn from one consistent value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            pendingDp    <= '0;
            pendingValid <= 1'b0;
            active       <= '0;
            activeDp     <= '0;
        end else if (load && frameBoundary) begin
            // A write landing on the boundary itself is the newest data: skip the buffer.
            active       <= value;
            activeDp     <= dp_in;
            pendingValid <= 1'b0;
        end else if (load) begin
            pending      <= value;
            pendingDp    <= dp_in;
            pendingValid <= 1'b1;
        end else if (frameBoundary && pendingValid) begin
            active       <= pending;
            activeDp     <= pendingDp;
            pendingValid <= 1'b0;
        end
    end

    // Select the nibble, decimal point and anode of the digit currently being scanned.
    always_comb begin
        curNibble = '0;
        curDp     = 1'b0;
        upperZero = 1'b0;
        anSel     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digitIdx == IDX_W'(i)) begin
                curNibble = active[4*i +: 4];
                curDp     = activeDp[i];
                upperZero = ~|(active >> (4*i));
                anSel[i]  = 1'b0;
            end
        end
    end

    // Leading zero: this nibble and every higher one are zero. Digit 0 always shows.
    assign blankDigit = blank_lz && (digitIdx != '0) && upperZero;

    // Registered pin drive. The first BLANK_CYC cycles of each slot keep all anodes off
    // so the previous digit's segments cannot ghost onto the newly selected anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frameBoundary;
            if (!enable || (divCnt < BLANK_END)) begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= anSel;
                seg <= blankDigit ? 7'h7F : ~hexGlyph(curNibble);
                dp  <= ~curDp;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 8-cycle dwell, 2-cycle blanking).
// A frame-position model predicts every output each cycle; literal checks pin key points.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seven_seg_scan;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int nChecks = 0;
    int nFails  = 0;
    bit started = 1'b0;

    seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Glyphs ABCDEFG, 1 = lit.
    logic [6:0] glyphTab [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Model: a single position inside the frame (0..FRAME-1), the displayed word and
    // the queued word. Expected outputs are what the pins show one cycle later.
    int          mPos = 0;
    int          mDig;
    logic [15:0] mAct = '0, mPend = '0;
    logic [3:0]  mActDp = '0, mPendDp = '0;
    bit          mPendV = 1'b0;
    bit          mBnd;
    logic [3:0]  eAn = 4'hF;
    logic [6:0]  eSeg = 7'h7F;
    logic        eDp = 1'b1;
    logic        eFd = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPos = 0; mAct = '0; mPend = '0; mActDp = '0; mPendDp = '0; mPendV = 1'b0;
            eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1; eFd = 1'b0;
        end else begin
            mDig = mPos / SD;
            mBnd = enable && (mPos == FRAME - 1);
            if (!enable || (mPos % SD) < BC) begin
                eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1;
            end else begin
                eAn = 4'hF;
                eAn[mDig] = 1'b0;
                if (blank_lz && mDig > 0 && (mAct >> (4*mDig)) == 16'h0)
                    eSeg = 7'h7F;
                else
                    eSeg = ~glyphTab[mAct[4*mDig +: 4]];
                eDp = ~mActDp[mDig];
            end
            eFd = mBnd;
            if (load && mBnd) begin
                mAct = value; mActDp = dp_in; mPendV = 1'b0;
            end else if (load) begin
                mPend = value; mPendDp = dp_in; mPendV = 1'b1;
            end else if (mBnd && mPendV) begin
                mAct = mPend; mActDp = mPendDp; mPendV = 1'b0;
            end
            if (enable) mPos = (mPos + 1) % FRAME;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got 'h%0h, required 'h%0h", name, $time, act, exp);
        end
    endtask

    // Every cycle: pins against the model.
    always @(negedge clk) begin
        if (started) begin
            check("model_an", {28'h0, an}, {28'h0, eAn});
            check("model_seg", {25'h0, seg}, {25'h0, eSeg});
            check("model_dp", {31'h0, dp}, {31'h0, eDp});
            check("model_frame_done", {31'h0, frame_done}, {31'h0, eFd});
        end
    end

    // Pins and model against hand-computed values.
    task automatic checkPoint(input string name, input logic [3:0] xAn, input logic [6:0] xSeg,
                              input logic xDp);
        check({name, "_an"}, {28'h0, an}, {28'h0, xAn});
        check({name, "_seg"}, {25'h0, seg}, {25'h0, xSeg});
        check({name, "_dp"}, {31'h0, dp}, {31'h0, xDp});
        check({name, "_model_an"}, {28'h0, eAn}, {28'h0, xAn});
        check({name, "_model_seg"}, {25'h0, eSeg}, {25'h0, xSeg});
        check({name, "_model_dp"}, {31'h0, eDp}, {31'h0, xDp});
    endtask

    // Stop on a falling edge where the counters sit at frame position p.
    task automatic waitPos(input int p);
        int n = 0;
        while (mPos != p && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (mPos != p) begin
            nChecks++;
            nFails++;
            $display("FAIL waitPos: position %0d, required %0d", mPos, p);
        end
    endtask

    // Stop where the pins show the slot of frame position p.
    task automatic showPos(input int p);
        waitPos((p + 1) % FRAME);
    endtask

    task automatic loadAt(input int p, input logic [15:0] v, input logic [3:0] d);
        waitPos(p);
        load = 1'b1; value = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int cnt;

        // 1. Reset and the blank "0000" frame.
        #2 rst_n = 1'b0;
        started = 1'b1;
        #1 checkPoint("rst", 4'hF, 7'h7F, 1'b1);
        check("rst_fd", {31'h0, frame_done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        showPos(1);  checkPoint("blank_slot", 4'hF, 7'h7F, 1'b1);
        showPos(2);  checkPoint("d0_first_lit", 4'b1110, 7'b0000001, 1'b1);
        showPos(7);  checkPoint("d0_last_lit", 4'b1110, 7'b0000001, 1'b1);
        showPos(31); checkPoint("d3_end", 4'b0111, 7'b0000001, 1'b1);
        check("first_frame_done", {31'h0, frame_done}, 32'h1);
        cnt = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (frame_done) cnt++;
        end
        check("frame_done_per_64", cnt, 2);

        // Reset in the middle of a dwell, away from any clock edge.
        waitPos(13);
        #3 rst_n = 1'b0;
        #1 checkPoint("mid_rst", 4'hF, 7'h7F, 1'b1);
        check("mid_rst_fd", {31'h0, frame_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2. Mid-frame load waits for the frame boundary.
        loadAt(10, 16'h1234, 4'b0100);
        showPos(20); checkPoint("old_frame_d2", 4'b1011, 7'b0000001, 1'b1);
        showPos(31);
        showPos(3);  checkPoint("new_d0_4", 4'b1110, 7'b1001100, 1'b1);
        showPos(20); checkPoint("new_d2_2_dp", 4'b1011, 7'b0010010, 1'b0);
        showPos(26); checkPoint("new_d3_1", 4'b0111, 7'b1001111, 1'b1);

        // 3. Two loads in one frame: only the last reaches the display.
        loadAt(5, 16'hABCD, 4'b0000);
        loadAt(12, 16'h00F0, 4'b0000);
        showPos(31);
        showPos(10); checkPoint("last_wins_d1_F", 4'b1101, 7'b0111000, 1'b1);
        showPos(26); checkPoint("last_wins_d3_0", 4'b0111, 7'b0000001, 1'b1);

        // 4. Load on the boundary bypasses the buffer and discards what was queued.
        loadAt(20, 16'h1111, 4'b1111);
        loadAt(31, 16'h5A5A, 4'b0000);
        showPos(3);  checkPoint("bypass_d0_A", 4'b1110, 7'b0001000, 1'b1);
        showPos(12); checkPoint("bypass_d1_5", 4'b1101, 7'b0100100, 1'b1);
        showPos(31);
        showPos(3);  checkPoint("no_stale_d0_A", 4'b1110, 7'b0001000, 1'b1);

        // 5. Leading-zero suppression.
        blank_lz = 1'b1;
        loadAt(15, 16'h0050, 4'b0100);
        showPos(31);
        showPos(5);  checkPoint("lz_d0_0", 4'b1110, 7'b0000001, 1'b1);
        showPos(13); checkPoint("lz_d1_5", 4'b1101, 7'b0100100, 1'b1);
        showPos(21); checkPoint("lz_d2_blank_dp", 4'b1011, 7'h7F, 1'b0);
        showPos(29); checkPoint("lz_d3_blank", 4'b0111, 7'h7F, 1'b1);
        loadAt(30, 16'h0000, 4'b0000);
        showPos(31);
        showPos(5);  checkPoint("lz_zero_d0", 4'b1110, 7'b0000001, 1'b1);
        showPos(13); checkPoint("lz_zero_d1", 4'b1101, 7'h7F, 1'b1);
        showPos(21); checkPoint("lz_zero_d2", 4'b1011, 7'h7F, 1'b1);

        // 6. Freeze during digit 2 at dwell count 5, then resume.
        blank_lz = 1'b0;
        loadAt(14, 16'h1234, 4'b0000);
        showPos(31);
        waitPos(21);
        enable = 1'b0;
        cnt = 0;
        @(negedge clk);
        checkPoint("hold_first", 4'hF, 7'h7F, 1'b1);
        if (frame_done) cnt++;
        repeat (19) begin
            @(negedge clk);
            if (frame_done) cnt++;
        end
        checkPoint("hold_last", 4'hF, 7'h7F, 1'b1);
        check("hold_no_fd", cnt, 0);
        enable = 1'b1;
        @(negedge clk);
        checkPoint("resume_d2", 4'b1011, 7'b0010010, 1'b1);
        // Dwell counts 5..7 of digit 2, then all 8 of digit 3.
        cnt = 1;
        while (!frame_done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("resume_frame_len", cnt, 11);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
